pe_bus_bridge: RTL and testbench
================================

Name: pe_bus_bridge

Overview:
Parametrised successor to the single-transaction PE bus interface. Queues PE memory and register-file requests in a FIFO and arbitrates for the shared bus via request/grant. Issues queued requests in bursts of up to MAX_BURST, with a per-transaction ack timeout, and returns one response per request to the PE. Sits between a processing_element and the shared CGRA bus/arbiter.

Parameters:
DATA_W, 32, data path width
ADDR_W, 32, memory address width; register index uses addr[4:0]
FIFO_DEPTH, 4, request queue entries (power of 2, >=2)
MAX_BURST, 4, max transactions per grant before bus_request must drop
TIMEOUT, 255, max cycles waiting for ack/ready per transaction

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pe_req_valid  in  1  PE request strobe
pe_req_ready  out  1  queue can accept
pe_req_type  in  2  00 mem read, 01 mem write, 10 reg read, 11 reg write
pe_req_addr  in  ADDR_W  memory address / register index
pe_req_data  in  DATA_W  write data
pe_done  in  1  PE has finished execution
pe_rsp_valid  out  1  one-cycle response pulse
pe_rsp_data  out  DATA_W  read data (0 for writes)
pe_rsp_err  out  1  transaction timed out
exec_complete  out  1  pe_done seen and all traffic drained
bus_request  out  1  to arbiter
grant  in  1  from arbiter
bus_mem_read / bus_mem_write / bus_reg_read / bus_reg_write  out  1 each  strobes
bus_addr  out  ADDR_W  address
bus_wdata  out  DATA_W  write data
mem_ack  in  1  global memory completion
data_ready  in  1  register-file completion
bus_rdata  in  DATA_W  read data

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM IDLE, burst and timeout counters 0, every output 0 except pe_req_ready=1. Reset mid-transaction discards queue and in-flight op; no response issued.
- FIFO: push when pe_req_valid&&pe_req_ready. pe_req_ready = (count<FIFO_DEPTH); a pop in the same cycle does not make a full queue ready. Pointers wrap modulo FIFO_DEPTH. Simultaneous push+pop keeps count.
- FSM IDLE: FIFO non-empty -> REQ.
- REQ: bus_request=1. grant=1 -> ISSUE (head entry latched).
- ISSUE: bus_request=1; exactly one strobe per type; bus_addr/bus_wdata from head (wdata 0 for reads). Completion = mem_ack for mem types, data_ready for reg types (other ack ignored). On completion: pop, capture bus_rdata for reads -> RESP. Timeout counter increments per ISSUE cycle; reaching TIMEOUT without completion: pop, err -> RESP. grant=0 in ISSUE: strobes drop same cycle, entry not popped, timeout counter cleared, -> REQ (retry).
- RESP (1 cycle): pe_rsp_valid=1, pe_rsp_data, pe_rsp_err. Strobes 0. burst_cnt++. If FIFO non-empty, grant=1 and burst_cnt<MAX_BURST -> ISSUE with bus_request held; else -> RELEASE.
- RELEASE (1 cycle): bus_request=0, burst_cnt=0 -> IDLE. Guarantees a one-cycle release to the arbiter after every burst.
- Latency: grant already high -> request pushed in cycle N strobes bus at N+2 (IDLE, REQ); response pulse the cycle after ack.
- Responses strictly in request order; no backpressure on responses.
- exec_complete: sticky flag set on pe_done; output = flag && FIFO empty && FSM IDLE. Cleared only by reset.
- Outputs registered except pe_req_ready.

Test Plan:
- Single mem write addr=0x100, data=0xDEADBEEF, grant 1 cycle after request, mem_ack after 3 cycles -> bus_mem_write high 3 cycles with addr/data stable, pe_rsp_valid pulse err=0, then bus_request low 1 cycle.
- Push 6 reg reads (DEPTH=4), grant held -> pe_req_ready low after 4 queued; bursts of 4 then release then 2; 6 in-order responses carrying bus_rdata values.
- No ack, TIMEOUT=255 -> strobe held exactly 255 cycles, pe_rsp_err=1, pe_rsp_data=0, next entry proceeds.
- grant dropped on 2nd ISSUE cycle of mem read -> strobe falls, bus_request stays, reissue on re-grant, single response.
- Reg write answered by mem_ack only -> ignored; completes on data_ready.
- pe_done while 2 requests queued -> exec_complete rises only after last response and IDLE; reset mid-ISSUE clears all outputs asynchronously.

Source files
------------

// File: rtl/pe_bus_bridge.sv
// Bridge between a processing element and the shared CGRA bus: queues PE requests,
// arbitrates for the bus, issues them in bounded bursts with a per-transaction timeout.
module pe_bus_bridge #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pe_req_valid,
    output logic              pe_req_ready,
    input  logic [1:0]        pe_req_type,
    input  logic [ADDR_W-1:0] pe_req_addr,
    input  logic [DATA_W-1:0] pe_req_data,
    input  logic              pe_done,
    output logic              pe_rsp_valid,
    output logic [DATA_W-1:0] pe_rsp_data,
    output logic              pe_rsp_err,
    output logic              exec_complete,
    output logic              bus_request,
    input  logic              grant,
    output logic              bus_mem_read,
    output logic              bus_mem_write,
    output logic              bus_reg_read,
    output logic              bus_reg_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              mem_ack,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    // kind[1]: register file target, kind[0]: write
    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_RESP,
        ST_RELEASE
    } state_e;

    req_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_c, pop_c;
    req_t              head_c;

    state_e            state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              done_flag_q, done_flag_d;

    logic              bus_request_q, bus_request_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              reg_rd_q, reg_rd_d;
    logic              reg_wr_q, reg_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              exec_q, exec_d;

    logic              head_is_reg_c, head_is_wr_c, head_done_c;

    // Request queue: a pop never frees a slot for a push in the same cycle
    assign pe_req_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push_c       = pe_req_valid && pe_req_ready;
    assign head_c       = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= '{kind: pe_req_type, addr: pe_req_addr, data: pe_req_data};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign head_is_reg_c = head_c.kind[1];
    assign head_is_wr_c  = head_c.kind[0];
    assign head_done_c   = head_is_reg_c ? data_ready : mem_ack;

    // Next state, counters and next values of every registered output
    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        tmo_d         = '0;
        pop_c         = 1'b0;
        bus_request_d = 1'b0;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        reg_rd_d      = 1'b0;
        reg_wr_d      = 1'b0;
        addr_d        = '0;
        wdata_d       = '0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = '0;
        rsp_err_d     = 1'b0;
        done_flag_d   = done_flag_q || pe_done;
        exec_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (head_done_c) begin
                    pop_c       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = head_is_wr_c ? '0 : bus_rdata;
                    state_d     = ST_RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    pop_c       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else if (!grant) begin
                    state_d = ST_REQ;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                burst_d = burst_q + BURST_W'(1);
                if ((count_q != '0) && grant && (burst_d < BURST_W'(MAX_BURST))) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                burst_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus_request_d = (state_d == ST_REQ) || (state_d == ST_ISSUE) || (state_d == ST_RESP);

        // The head entry is stable while issued; it only leaves on the completing edge
        if (state_d == ST_ISSUE) begin
            mem_rd_d = !head_is_reg_c && !head_is_wr_c;
            mem_wr_d = !head_is_reg_c &&  head_is_wr_c;
            reg_rd_d =  head_is_reg_c && !head_is_wr_c;
            reg_wr_d =  head_is_reg_c &&  head_is_wr_c;
            addr_d   = head_is_reg_c ? ADDR_W'(head_c.addr[4:0]) : head_c.addr;
            wdata_d  = head_is_wr_c ? head_c.data : '0;
        end

        exec_d = done_flag_d && (count_d == '0) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            burst_q       <= '0;
            tmo_q         <= '0;
            done_flag_q   <= 1'b0;
            bus_request_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            reg_rd_q      <= 1'b0;
            reg_wr_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            exec_q        <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q       <= count_d;
            state_q       <= state_d;
            burst_q       <= burst_d;
            tmo_q         <= tmo_d;
            done_flag_q   <= done_flag_d;
            bus_request_q <= bus_request_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            reg_rd_q      <= reg_rd_d;
            reg_wr_q      <= reg_wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            exec_q        <= exec_d;
        end
    end

    assign bus_request   = bus_request_q;
    assign bus_mem_read  = mem_rd_q;
    assign bus_mem_write = mem_wr_q;
    assign bus_reg_read  = reg_rd_q;
    assign bus_reg_write = reg_wr_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign pe_rsp_valid  = rsp_valid_q;
    assign pe_rsp_data   = rsp_data_q;
    assign pe_rsp_err    = rsp_err_q;
    assign exec_complete = exec_q;

endmodule

// File: tb/tb_pe_bus_bridge.sv
// Directed bench for pe_bus_bridge; expected responses are queued at issue time and
// checked by an independent response monitor.
module tb_pe_bus_bridge;

    localparam logic [1:0] MEM_RD = 2'b00;
    localparam logic [1:0] MEM_WR = 2'b01;
    localparam logic [1:0] REG_RD = 2'b10;
    localparam logic [1:0] REG_WR = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pe_req_valid = 1'b0;
    logic        pe_req_ready;
    logic [1:0]  pe_req_type = 2'b00;
    logic [31:0] pe_req_addr = '0;
    logic [31:0] pe_req_data = '0;
    logic        pe_done = 1'b0;
    logic        pe_rsp_valid;
    logic [31:0] pe_rsp_data;
    logic        pe_rsp_err;
    logic        exec_complete;
    logic        bus_request;
    logic        grant = 1'b0;
    logic        bus_mem_read, bus_mem_write, bus_reg_read, bus_reg_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        mem_ack = 1'b0;
    logic        data_ready = 1'b0;
    logic [31:0] bus_rdata;
    logic [31:0] rd_base = 32'h5A5A_0000;

    // Bus slave model: read data is a fixed base OR'd with the presented address
    assign bus_rdata = rd_base | bus_addr;

    pe_bus_bridge dut (
        .clk(clk), .reset(reset),
        .pe_req_valid(pe_req_valid), .pe_req_ready(pe_req_ready),
        .pe_req_type(pe_req_type), .pe_req_addr(pe_req_addr), .pe_req_data(pe_req_data),
        .pe_done(pe_done), .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data),
        .pe_rsp_err(pe_rsp_err), .exec_complete(exec_complete),
        .bus_request(bus_request), .grant(grant),
        .bus_mem_read(bus_mem_read), .bus_mem_write(bus_mem_write),
        .bus_reg_read(bus_reg_read), .bus_reg_write(bus_reg_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .mem_ack(mem_ack), .data_ready(data_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   rsp_total = 0;
    int   burst_run = 0;
    int   bursts[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && pe_rsp_valid) begin
            rsp_total++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got data 0x%0h err %0b with nothing outstanding",
                         pe_rsp_data, pe_rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 64'(pe_rsp_data), 64'(e.data));
                check("rsp_err", 64'(pe_rsp_err), 64'(e.err));
            end
        end
    end

    // Burst length tracker: responses between bus_request releases
    always @(negedge clk) begin
        if (!reset) begin
            burst_run = 0;
        end else begin
            if (pe_rsp_valid) burst_run++;
            if (!bus_request && burst_run != 0) begin
                bursts.push_back(burst_run);
                burst_run = 0;
            end
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return bus_request;
            1: return bus_mem_read;
            2: return bus_mem_write;
            3: return bus_reg_read;
            4: return bus_reg_write;
            5: return exec_complete;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input string name, input int w, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (sel(w)) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: signal still low after %0d cycles, required high", name, budget);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee);
        bit done = 1'b0;
        pe_req_type  = t;
        pe_req_addr  = a;
        pe_req_data  = d;
        pe_req_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (pe_req_ready) begin
                sb.push_back('{err: ee, data: ed});
                done = 1'b1;
            end
            tick();
        end
        pe_req_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_accept: ready stayed 0 for addr 0x%0h, required 1", a);
        end
    endtask

    task automatic drain(input string name, input int budget);
        bit idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            if (sb.size() == 0 && !bus_request) idle = 1'b1;
            else tick();
        end
        if (!idle) begin
            total++;
            bad++;
            $display("FAIL %s: %0d responses outstanding after %0d cycles, required 0",
                     name, sb.size(), budget);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;

        // Reset state
        repeat (3) tick();
        check("rst_req_ready", 64'(pe_req_ready), 64'd1);
        check("rst_bus_request", 64'(bus_request), 64'd0);
        check("rst_strobes", 64'({bus_mem_read, bus_mem_write, bus_reg_read, bus_reg_write}), 64'd0);
        check("rst_rsp_valid", 64'(pe_rsp_valid), 64'd0);
        check("rst_exec", 64'(exec_complete), 64'd0);
        reset = 1'b1;
        tick();

        // Single memory write, late grant, ack in the third issue cycle
        push(MEM_WR, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        wait_hi("t1_request", 0, 5);
        check("t1_bus_request", 64'(bus_request), 64'd1);
        tick();
        grant = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t1_mem_write", 64'(bus_mem_write), 64'd1);
            check("t1_addr", 64'(bus_addr), 64'h100);
            check("t1_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("t1_strobe_drop", 64'(bus_mem_write), 64'd0);
        check("t1_rsp_pulse", 64'(pe_rsp_valid), 64'd1);
        check("t1_req_in_resp", 64'(bus_request), 64'd1);
        tick();
        check("t1_release", 64'(bus_request), 64'd0);
        check("t1_rsp_one_cycle", 64'(pe_rsp_valid), 64'd0);
        grant = 1'b0;
        drain("t1_drain", 20);

        // Six register reads through a four-deep queue, grant held
        bursts.delete();
        grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(REG_RD, 32'(i), 32'h0, rd_base | 32'(i), 1'b0);
        end
        check("t2_full_not_ready", 64'(pe_req_ready), 64'd0);
        check("t2_issue_reg_read", 64'(bus_reg_read), 64'd1);
        data_ready = 1'b1;
        push(REG_RD, 32'd4, 32'h0, rd_base | 32'd4, 1'b0);
        push(REG_RD, 32'd5, 32'h0, rd_base | 32'd5, 1'b0);
        drain("t2_drain", 60);
        data_ready = 1'b0;
        check("t2_burst_count", 64'(bursts.size()), 64'd2);
        if (bursts.size() == 2) begin
            check("t2_burst0_len", 64'(bursts[0]), 64'd4);
            check("t2_burst1_len", 64'(bursts[1]), 64'd2);
        end

        // Timeout on an unanswered read; the following write still completes
        push(MEM_RD, 32'h200, 32'h0, 32'h0, 1'b1);
        push(MEM_WR, 32'h204, 32'hCAFE_F00D, 32'h0, 1'b0);
        wait_hi("t3_read_strobe", 1, 10);
        n = 0;
        while (bus_mem_read && n < 400) begin
            n++;
            tick();
        end
        check("t3_strobe_cycles", 64'(n), 64'd255);
        check("t3_rsp_err", 64'(pe_rsp_err), 64'd1);
        check("t3_rsp_data", 64'(pe_rsp_data), 64'd0);
        wait_hi("t3_next_entry", 2, 10);
        check("t3_next_addr", 64'(bus_addr), 64'h204);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        drain("t3_drain", 20);

        // Grant withdrawn on the second issue cycle of a memory read
        grant = 1'b0;
        r0 = rsp_total;
        push(MEM_RD, 32'h300, 32'hFFFF_FFFF, rd_base | 32'h300, 1'b0);
        wait_hi("t4_request", 0, 5);
        grant = 1'b1;
        tick();
        check("t4_issue1", 64'(bus_mem_read), 64'd1);
        check("t4_read_wdata", 64'(bus_wdata), 64'd0);
        tick();
        check("t4_issue2", 64'(bus_mem_read), 64'd1);
        grant = 1'b0;
        tick();
        check("t4_strobe_dropped", 64'(bus_mem_read), 64'd0);
        check("t4_request_held", 64'(bus_request), 64'd1);
        tick();
        check("t4_no_early_rsp", 64'(pe_rsp_valid), 64'd0);
        grant = 1'b1;
        tick();
        check("t4_reissue", 64'(bus_mem_read), 64'd1);
        check("t4_reissue_addr", 64'(bus_addr), 64'h300);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        drain("t4_drain", 20);
        check("t4_single_rsp", 64'(rsp_total - r0), 64'd1);

        // Register write ignores mem_ack, completes on data_ready; index is addr[4:0]
        push(REG_WR, 32'h3F, 32'h1234_5678, 32'h0, 1'b0);
        wait_hi("t5_strobe", 4, 10);
        check("t5_reg_index", 64'(bus_addr), 64'h1F);
        check("t5_wdata", 64'(bus_wdata), 64'h1234_5678);
        mem_ack = 1'b1;
        repeat (3) tick();
        mem_ack = 1'b0;
        check("t5_ignores_mem_ack", 64'(bus_reg_write), 64'd1);
        check("t5_no_rsp", 64'(pe_rsp_valid), 64'd0);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("t5_done_strobe", 64'(bus_reg_write), 64'd0);
        check("t5_done_rsp", 64'(pe_rsp_valid), 64'd1);
        drain("t5_drain", 20);
        grant = 1'b0;

        // exec_complete waits for the queue to drain and the FSM to return to idle
        check("t6_exec_before", 64'(exec_complete), 64'd0);
        r0 = rsp_total;
        push(MEM_RD, 32'h10, 32'h0, rd_base | 32'h10, 1'b0);
        push(MEM_RD, 32'h14, 32'h0, rd_base | 32'h14, 1'b0);
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        tick();
        check("t6_exec_pending", 64'(exec_complete), 64'd0);
        grant = 1'b1;
        mem_ack = 1'b1;
        wait_hi("t6_exec", 5, 30);
        check("t6_rsps_first", 64'(rsp_total - r0), 64'd2);
        check("t6_bus_idle", 64'(bus_request), 64'd0);
        mem_ack = 1'b0;
        tick();
        check("t6_exec_sticky", 64'(exec_complete), 64'd1);

        // Asynchronous reset in the middle of an issue discards everything
        push(MEM_WR, 32'h400, 32'h0BAD_F00D, 32'h0, 1'b0);
        wait_hi("t7_strobe", 2, 10);
        #2;
        reset = 1'b0;
        void'(sb.pop_back());
        #1;
        check("t7_rst_strobe", 64'(bus_mem_write), 64'd0);
        check("t7_rst_request", 64'(bus_request), 64'd0);
        check("t7_rst_addr", 64'(bus_addr), 64'd0);
        check("t7_rst_exec", 64'(exec_complete), 64'd0);
        check("t7_rst_ready", 64'(pe_req_ready), 64'd1);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("t7_queue_discarded", 64'(bus_request), 64'd0);
        check("t7_flag_cleared", 64'(exec_complete), 64'd0);
        check("t7_no_stale_rsp", 64'(sb.size()), 64'd0);
        grant = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
